ponto_fixo_8_bcd: RTL and testbench
===================================

# ponto_fixo_8_bcd

Sequential decoder that turns one unsigned Q4.4 word, the format produced by the team's 8-bit fixed-point add/sub unit, into decimal digits for display. The integer part becomes 2 BCD digits and the fraction becomes 4 exact BCD digits (k/16 = k×0.0625). It sits between the arithmetic datapath and the 7-segment/LCD drivers and latches the arithmetic overflow flag next to the digits. It uses a start/busy/done handshake and a fixed 4-step iteration.

## Interface
- Parameters: none; the format is fixed at Q4.4 through the shared package constants.
- `clk  in  1` — single clock, rising edge.
- `rst_n  in  1` — asynchronous, active-low reset.
- `start  in  1` — conversion request, sampled only in IDLE.
- `value  in  8` — Q4.4 operand: bits [7:4] integer, bits [3:0] fraction.
- `ovf_in  in  1` — overflow/borrow flag of the producer, latched with `value`.
- `int_bcd  out  8` — integer part: [7:4] tens, [3:0] ones (00..15).
- `frac_bcd  out  16` — fraction digits, [15:12] = 10^-1 down to [3:0] = 10^-4 (0000..9375).
- `ovf_out  out  1` — `ovf_in` captured at the accepted start.
- `busy  out  1` — high in CONV and DONE.
- `done  out  1` — one-cycle pulse; outputs are valid from this cycle on.

## Operation
- States: IDLE, CONV, DONE.
  - IDLE→CONV on `start`=1: latch `value` into the int and frac working registers, latch `ovf_in`, clear the step counter and the BCD accumulators.
  - CONV runs exactly 4 steps; after step 3 it moves to DONE.
  - DONE→IDLE unconditionally after 1 cycle.
- Integer step (double-dabble):
  - In the 8-bit BCD accumulator, add 3 to each nibble that is ≥5.
  - Then shift left 1 and bring in the MSB of the int working register.
  - Then shift the int working register left 1.
- Fraction step (×10):
  - p = f×10 (8-bit); the next digit is p[7:4].
  - f ← p[3:0].
  - Shift the digit into `frac_bcd` from the right, so the first digit ends up in [15:12].
  - Four steps give an exact result with no rounding.
- Output registers `int_bcd`, `frac_bcd` and `ovf_out` are written only on the CONV→DONE edge. They hold until the next completion and never show partial values.
- `start` is ignored while `busy`=1, including in the DONE cycle. It is not queued.
- `value` and `ovf_in` may change freely after the accepting edge.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `int_bcd`=0x00, `frac_bcd`=0x0000, `ovf_out`=0, `busy`=0, `done`=0, working registers and counter 0.
- Latency: `start` accepted at edge N. CONV occupies edges N+1..N+4. `done`=1 and the outputs are valid in the cycle after edge N+4, i.e. 5 cycles from acceptance.
- Throughput: a new `start` can be accepted at edge N+6, the first edge with IDLE. The minimum period is 6 cycles.
- `busy` rises in the cycle after edge N and falls at the start of the cycle after the DONE cycle.
- Reset mid-conversion aborts immediately:
  - All outputs take their reset values.
  - No `done` pulse is generated for the aborted request.
  - The first `start` after release is handled normally.
- `start` held high continuously restarts a conversion every 6 cycles, each with a fresh `value` sample.

## Structure
- Package `ponto_fixo_pkg` holds:
  - `Q_INT`=4, `Q_FRAC`=4, `N_STEPS`=4, `N_FRAC_DIGITS`=4;
  - the state enum {IDLE, CONV, DONE};
  - typedefs for the BCD digit (4 bits) and the Q4.4 word.
- Sub-module `ponto_fixo_bcd_step`: a purely combinational single iteration.
  - In: BCD accumulator, int MSB, frac residue.
  - Out: next accumulator, next residue, new fraction digit.
  - The top level holds the FSM, the counter and the registers only.

## Test plan
- Reset, then `value`=0x38 (3.5) with `start` → `done` at +5 cycles; `int_bcd`=0x03, `frac_bcd`=0x5000, `ovf_out`=0.
- `value`=0xFF, `ovf_in`=1 → `int_bcd`=0x15, `frac_bcd`=0x9375, `ovf_out`=1.
- `value`=0x01, then `value`=0x00 → 0x00/0x0625, then 0x00/0x0000.
- 0xA3 is accepted, then `start` is pulsed with 0x11 during CONV and in the DONE cycle → both pulses ignored; one `done`; result 0x10/0x1875; `busy` low only after DONE.
- `rst_n` low at CONV step 2 → outputs zero immediately; no `done`. Next conversion of 0x7C gives 0x07/0x7500.
- Exhaustive sweep 0x00..0xFF with back-to-back `start` → each result matches the reference model (int = v>>4, frac = (v&15)×625), one `done` per request, 6-cycle spacing.

Source files
------------

// File: rtl/ponto_fixo_pkg.sv
// ponto_fixo_pkg
//   Shared constants and types for the Q4.4 -> BCD display decoder.
//   Q_INT / Q_FRAC    : integer / fraction widths of the fixed-point word.
//   N_STEPS           : number of combined integer/fraction iterations.
//   N_FRAC_DIGITS     : number of exact decimal fraction digits produced.
//   state_t           : decoder FSM states.
//   bcd_digit_t/q44_t : one BCD digit, one Q4.4 word.
package ponto_fixo_pkg;

  localparam int unsigned Q_INT         = 4;
  localparam int unsigned Q_FRAC        = 4;
  localparam int unsigned N_STEPS       = 4;
  localparam int unsigned N_FRAC_DIGITS = 4;
  localparam int unsigned CNT_W         = $clog2(N_STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [3:0]              bcd_digit_t;
  typedef logic [Q_INT+Q_FRAC-1:0] q44_t;

endpackage

// File: rtl/ponto_fixo_bcd_step.sv
// ponto_fixo_bcd_step
//   One combinational iteration of the Q4.4 -> BCD conversion.
//   acc_i     : 2-digit BCD accumulator of the integer part (double-dabble).
//   int_msb_i : next integer bit to shift in, MSB first.
//   frac_i    : fraction residue (k/16 numerator).
//   acc_o     : accumulator after add-3 correction and shift.
//   frac_o    : residue after multiplying by ten.
//   digit_o   : decimal fraction digit produced by this iteration.
module ponto_fixo_bcd_step
  import ponto_fixo_pkg::*;
(
  input  logic [7:0]  acc_i,
  input  logic        int_msb_i,
  input  logic [3:0]  frac_i,
  output logic [7:0]  acc_o,
  output logic [3:0]  frac_o,
  output bcd_digit_t  digit_o
);

  bcd_digit_t adj_hi;
  bcd_digit_t adj_lo;
  logic [7:0] prod;

  always_comb begin
    adj_hi = acc_i[7:4];
    adj_lo = acc_i[3:0];
    if (acc_i[7:4] >= 4'd5) adj_hi = acc_i[7:4] + 4'd3;
    if (acc_i[3:0] >= 4'd5) adj_lo = acc_i[3:0] + 4'd3;
    // The top corrected bit shifts out; it is always zero for a 4-bit integer.
    acc_o = 8'({adj_hi, adj_lo, int_msb_i});
  end

  // f*10 < 160, so the upper nibble is the next decimal digit and the
  // lower nibble is the exact remaining sixteenths.
  always_comb begin
    prod    = {4'b0000, frac_i} * 8'd10;
    digit_o = prod[7:4];
    frac_o  = prod[3:0];
  end

endmodule

// File: rtl/ponto_fixo_8_bcd.sv
// ponto_fixo_8_bcd
//   Sequential Q4.4 -> decimal decoder with start/busy/done handshake.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset.
//   start      : conversion request, sampled only in IDLE.
//   value      : Q4.4 operand ([7:4] integer, [3:0] fraction).
//   ovf_in     : producer overflow flag, captured with value.
//   int_bcd    : integer part, tens in [7:4], ones in [3:0].
//   frac_bcd   : four fraction digits, 10^-1 in [15:12].
//   ovf_out    : ovf_in captured at the accepted start.
//   busy       : high in CONV and DONE.
//   done       : one-cycle pulse when outputs are updated.
module ponto_fixo_8_bcd
  import ponto_fixo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  value,
  input  logic        ovf_in,
  output logic [7:0]  int_bcd,
  output logic [15:0] frac_bcd,
  output logic        ovf_out,
  output logic        busy,
  output logic        done
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [Q_INT-1:0]   int_q, int_d;
  logic [Q_FRAC-1:0]  frac_q, frac_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         acc_q, acc_d;
  // Holds the first three fraction digits; the fourth comes straight from
  // the step logic on the final iteration.
  logic [11:0]        fdig_q, fdig_d;
  logic [7:0]         int_bcd_q, int_bcd_d;
  logic [15:0]        frac_bcd_q, frac_bcd_d;
  logic               ovf_out_q, ovf_out_d;

  logic [7:0]         step_acc;
  logic [3:0]         step_frac;
  bcd_digit_t         step_digit;
  q44_t               value_w;

  assign value_w = value;

  ponto_fixo_bcd_step u_step (
    .acc_i     (acc_q),
    .int_msb_i (int_q[Q_INT-1]),
    .frac_i    (frac_q),
    .acc_o     (step_acc),
    .frac_o    (step_frac),
    .digit_o   (step_digit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    int_d      = int_q;
    frac_d     = frac_q;
    ovf_d      = ovf_q;
    acc_d      = acc_q;
    fdig_d     = fdig_q;
    int_bcd_d  = int_bcd_q;
    frac_bcd_d = frac_bcd_q;
    ovf_out_d  = ovf_out_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CONV;
          int_d   = value_w[Q_INT+Q_FRAC-1:Q_FRAC];
          frac_d  = value_w[Q_FRAC-1:0];
          ovf_d   = ovf_in;
          cnt_d   = '0;
          acc_d   = '0;
          fdig_d  = '0;
        end
      end
      CONV: begin
        acc_d  = step_acc;
        int_d  = {int_q[Q_INT-2:0], 1'b0};
        frac_d = step_frac;
        fdig_d = {fdig_q[7:0], step_digit};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_STEPS - 1)) begin
          state_d    = DONE;
          int_bcd_d  = step_acc;
          frac_bcd_d = {fdig_q, step_digit};
          ovf_out_d  = ovf_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      int_q      <= '0;
      frac_q     <= '0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
      fdig_q     <= '0;
      int_bcd_q  <= '0;
      frac_bcd_q <= '0;
      ovf_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_q      <= int_d;
      frac_q     <= frac_d;
      ovf_q      <= ovf_d;
      acc_q      <= acc_d;
      fdig_q     <= fdig_d;
      int_bcd_q  <= int_bcd_d;
      frac_bcd_q <= frac_bcd_d;
      ovf_out_q  <= ovf_out_d;
    end
  end

  assign int_bcd  = int_bcd_q;
  assign frac_bcd = frac_bcd_q;
  assign ovf_out  = ovf_out_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_ponto_fixo_8_bcd.sv
module tb_ponto_fixo_8_bcd;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  value;
  logic        ovf_in;
  logic [7:0]  int_bcd;
  logic [15:0] frac_bcd;
  logic        ovf_out;
  logic        busy;
  logic        done;

  int n_checks;
  int n_fail;

  ponto_fixo_8_bcd dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .value    (value),
    .ovf_in   (ovf_in),
    .int_bcd  (int_bcd),
    .frac_bcd (frac_bcd),
    .ovf_out  (ovf_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  v;
    logic        ovf;
    logic [7:0]  exp_int;
    logic [15:0] exp_frac;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts negedges after the accepting edge until done; 5 expected.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (done) return;
    end
  endtask

  // Decimal reference built from the number, independent of the RTL algorithm.
  function automatic logic [7:0] ref_int(input logic [7:0] v);
    int unsigned i;
    i = int'(v) >> 4;
    return 8'(((i / 10) << 4) | (i % 10));
  endfunction

  function automatic logic [15:0] ref_frac(input logic [7:0] v);
    int unsigned f;
    f = (int'(v) & 15) * 625;
    return 16'(((f / 1000) << 12) | (((f / 100) % 10) << 8) |
               (((f / 10) % 10) << 4) | (f % 10));
  endfunction

  task automatic run_vec(input vec_t t);
    int cyc;
    @(negedge clk);
    value  = t.v;
    ovf_in = t.ovf;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    value  = ~t.v;
    ovf_in = ~t.ovf;
    wait_done(cyc);
    check("latency", cyc, 5);
    check("int_bcd", int_bcd, t.exp_int);
    check("frac_bcd", frac_bcd, t.exp_frac);
    check("ovf_out", ovf_out, t.exp_ovf);
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("done_pulse_end", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int cyc;
    int last;
    int tcyc;
    n_checks = 0;
    n_fail   = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    value  = 8'h00;
    ovf_in = 1'b0;

    vecs[0] = '{8'h38, 1'b0, 8'h03, 16'h5000, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 8'h15, 16'h9375, 1'b1};
    vecs[2] = '{8'h01, 1'b0, 8'h00, 16'h0625, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 8'h00, 16'h0000, 1'b0};
    vecs[4] = '{8'h9A, 1'b1, 8'h09, 16'h6250, 1'b1};
    vecs[5] = '{8'h7C, 1'b0, 8'h07, 16'h7500, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_int", int_bcd, 0);
    check("rst_frac", frac_bcd, 0);
    check("rst_ovf", ovf_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Start pulses during CONV and in the DONE cycle must be ignored.
    @(negedge clk);
    value = 8'hA3; ovf_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = (c == 2 || c == 5);
      value = 8'h11;
      ovf_in = 1'b0;
      check($sformatf("ign_done_c%0d", c), done, (c == 5));
      check($sformatf("ign_busy_c%0d", c), busy, (c <= 5));
    end
    start = 1'b0;
    check("ign_int", int_bcd, 8'h10);
    check("ign_frac", frac_bcd, 16'h1875);
    check("ign_ovf", ovf_out, 1);

    // Reset in the middle of a conversion.
    @(negedge clk);
    value = 8'hFF; ovf_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_int", int_bcd, 0);
    check("abort_frac", frac_bcd, 0);
    check("abort_ovf", ovf_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    run_vec('{8'h7C, 1'b0, 8'h07, 16'h7500, 1'b0});

    // Exhaustive sweep with start held high.
    @(negedge clk);
    value = 8'h00; ovf_in = 1'b0; start = 1'b1;
    tcyc = 0;
    last = 0;
    for (int v = 0; v < 256; v++) begin
      wait_done(cyc);
      tcyc += cyc;
      if (cyc >= 20) begin
        check("sweep_timeout", cyc, 0);
        break;
      end
      check($sformatf("sweep_int_%02h", v), int_bcd, ref_int(8'(v)));
      check($sformatf("sweep_frac_%02h", v), frac_bcd, ref_frac(8'(v)));
      check($sformatf("sweep_ovf_%02h", v), ovf_out, 32'(v[7] ^ v[0]));
      if (v > 0) check($sformatf("sweep_period_%02h", v), tcyc - last, 6);
      last = tcyc;
      if (v == 255) start = 1'b0;
      value  = 8'(v + 1);
      ovf_in = (v + 1) % 2 == 1 ? ~((v + 1) >= 128) : ((v + 1) >= 128);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("sweep_no_extra_done", done, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
